// File: rtl/i2c_target.sv
// I2C target: oversampled SCL/SDA, START/STOP detection, 7-bit address match,
// byte-wide receive/transmit handshake toward the register side. SDA is open-drain.
module i2c_target #(
   parameter logic [6:0]  TARGET_ADDR = 7'h50,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_oe_o,
   input  logic       ack_en_i,
   input  logic [7:0] tx_data_i,
   output logic       tx_req_o,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   output logic       rw_o,
   output logic       busy_o,
   output logic       start_o,
   output logic       stop_o
);

   typedef enum logic [2:0] {
      StIdle,
      StAddr,
      StAddrAck,
      StRx,
      StRxAck,
      StTx,
      StTxAck
   } state_e;

   // Synchronizers reset high so a released bus never looks like an edge.
   logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
   logic                   scl_hist, sda_hist;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_hist <= 1'b1;
         sda_hist <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
         scl_hist <= scl_sync[SYNC_STAGES-1];
         sda_hist <= sda_sync[SYNC_STAGES-1];
      end
   end

   logic scl_s, sda_s;
   logic scl_rise, scl_fall, start_det, stop_det;

   assign scl_s     = scl_sync[SYNC_STAGES-1];
   assign sda_s     = sda_sync[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_hist;
   assign scl_fall  = ~scl_s & scl_hist;
   assign start_det = scl_s & scl_hist & sda_hist & ~sda_s;
   assign stop_det  = scl_s & scl_hist & ~sda_hist & sda_s;

   state_e     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       pend_q, pend_d;
   logic       sda_oe_q, sda_oe_d;
   logic       rx_valid_q, rx_valid_d;
   logic       tx_req_q, tx_req_d;
   logic       rw_q, rw_d;
   logic       busy_q, busy_d;
   logic       start_q, start_d;
   logic       stop_q, stop_d;
   logic [7:0] byte_in;

   assign byte_in = {shift_q[6:0], sda_s};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         shift_q    <= '0;
         rx_data_q  <= '0;
         pend_q     <= 1'b0;
         sda_oe_q   <= 1'b0;
         rx_valid_q <= 1'b0;
         tx_req_q   <= 1'b0;
         rw_q       <= 1'b0;
         busy_q     <= 1'b0;
         start_q    <= 1'b0;
         stop_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         rx_data_q  <= rx_data_d;
         pend_q     <= pend_d;
         sda_oe_q   <= sda_oe_d;
         rx_valid_q <= rx_valid_d;
         tx_req_q   <= tx_req_d;
         rw_q       <= rw_d;
         busy_q     <= busy_d;
         start_q    <= start_d;
         stop_q     <= stop_d;
      end
   end

   // pend_q marks "byte/ack bit seen at the rise, act on the following fall".
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      rx_data_d  = rx_data_q;
      pend_d     = pend_q;
      sda_oe_d   = sda_oe_q;
      rx_valid_d = 1'b0;
      tx_req_d   = 1'b0;
      rw_d       = rw_q;
      busy_d     = busy_q;
      start_d    = 1'b0;
      stop_d     = 1'b0;

      if (stop_det) begin
         stop_d   = 1'b1;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
         pend_d   = 1'b0;
         state_d  = StIdle;
      end else if (start_det) begin
         start_d  = 1'b1;
         sda_oe_d = 1'b0;
         pend_d   = 1'b0;
         cnt_d    = '0;
         state_d  = StAddr;
      end else begin
         unique case (state_q)
            StIdle: ;
            StAddr: begin
               if (scl_rise && !pend_q) begin
                  shift_d = byte_in;
                  cnt_d   = cnt_q + 3'd1;
                  if (cnt_q == 3'd7) begin
                     if (byte_in[7:1] == TARGET_ADDR) begin
                        rw_d   = byte_in[0];
                        busy_d = 1'b1;
                        pend_d = 1'b1;
                     end else begin
                        busy_d  = 1'b0;
                        state_d = StIdle;
                     end
                  end
               end else if (scl_fall && pend_q) begin
                  pend_d   = 1'b0;
                  sda_oe_d = 1'b1;
                  state_d  = StAddrAck;
               end
            end
            StAddrAck: begin
               if (scl_rise && rw_q) tx_req_d = 1'b1;
               if (scl_fall) begin
                  cnt_d = '0;
                  if (rw_q) begin
                     shift_d  = tx_data_i;
                     sda_oe_d = ~tx_data_i[7];
                     state_d  = StTx;
                  end else begin
                     sda_oe_d = 1'b0;
                     state_d  = StRx;
                  end
               end
            end
            StRx: begin
               if (scl_rise && !pend_q) begin
                  shift_d = byte_in;
                  cnt_d   = cnt_q + 3'd1;
                  if (cnt_q == 3'd7) begin
                     rx_data_d  = byte_in;
                     rx_valid_d = 1'b1;
                     pend_d     = 1'b1;
                  end
               end else if (scl_fall && pend_q) begin
                  pend_d   = 1'b0;
                  sda_oe_d = ack_en_i;
                  state_d  = StRxAck;
               end
            end
            StRxAck: begin
               // sda_oe_q still holds the ACK/NACK we drove during this bit.
               if (scl_fall) begin
                  sda_oe_d = 1'b0;
                  cnt_d    = '0;
                  if (sda_oe_q) begin
                     state_d = StRx;
                  end else begin
                     busy_d  = 1'b0;
                     state_d = StIdle;
                  end
               end
            end
            StTx: begin
               if (scl_rise && !pend_q) begin
                  cnt_d = cnt_q + 3'd1;
                  if (cnt_q == 3'd7) pend_d = 1'b1;
               end else if (scl_fall) begin
                  if (pend_q) begin
                     pend_d   = 1'b0;
                     sda_oe_d = 1'b0;
                     state_d  = StTxAck;
                  end else begin
                     shift_d  = {shift_q[6:0], 1'b0};
                     sda_oe_d = ~shift_q[6];
                  end
               end
            end
            StTxAck: begin
               if (scl_rise && !pend_q) begin
                  if (!sda_s) begin
                     tx_req_d = 1'b1;
                     pend_d   = 1'b1;
                  end else begin
                     busy_d  = 1'b0;
                     state_d = StIdle;
                  end
               end else if (scl_fall && pend_q) begin
                  pend_d   = 1'b0;
                  cnt_d    = '0;
                  shift_d  = tx_data_i;
                  sda_oe_d = ~tx_data_i[7];
                  state_d  = StTx;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   assign sda_oe_o   = sda_oe_q;
   assign tx_req_o   = tx_req_q;
   assign rx_data_o  = rx_data_q;
   assign rx_valid_o = rx_valid_q;
   assign rw_o       = rw_q;
   assign busy_o     = busy_q;
   assign start_o    = start_q;
   assign stop_o     = stop_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-banged bus master plus a transaction-level model
// of what the target should ACK, receive and return.
`timescale 1ns/1ps
module tb_i2c_target;

   localparam logic [6:0] TADDR   = 7'h50;
   localparam int         QUARTER = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       scl, sda_m, sda_bus;
   logic       sda_oe, ack_en, tx_req, rx_valid, rw, busy, start_p, stop_p;
   logic [7:0] tx_data, rx_data;

   logic [7:0] tx_mem [16];
   logic [7:0] rx_log [16];
   logic [7:0] wdata  [8];
   int         start_cnt = 0, stop_cnt = 0, rx_cnt = 0, tx_cnt = 0, oe_cnt = 0;
   int         checks = 0, failures = 0;

   always #5 clk = ~clk;

   assign sda_bus = sda_m & ~sda_oe;
   assign tx_data = tx_mem[tx_cnt % 16];

   i2c_target #(.TARGET_ADDR(TADDR), .SYNC_STAGES(2)) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .scl_i     (scl),
      .sda_i     (sda_bus),
      .sda_oe_o  (sda_oe),
      .ack_en_i  (ack_en),
      .tx_data_i (tx_data),
      .tx_req_o  (tx_req),
      .rx_data_o (rx_data),
      .rx_valid_o(rx_valid),
      .rw_o      (rw),
      .busy_o    (busy),
      .start_o   (start_p),
      .stop_o    (stop_p)
   );

   // Event log, sampled on the inactive edge.
   always @(negedge clk) begin
      if (start_p) start_cnt++;
      if (stop_p) stop_cnt++;
      if (tx_req) tx_cnt++;
      if (sda_oe) oe_cnt++;
      if (rx_valid) begin
         rx_log[rx_cnt % 16] = rx_data;
         rx_cnt++;
      end
   end

   initial begin
      #900_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_q();
      repeat (QUARTER) @(posedge clk);
      #1;
   endtask

   task automatic send_start();
      sda_m = 1'b1; wait_q();
      scl   = 1'b1; wait_q();
      sda_m = 1'b0; wait_q();
      scl   = 1'b0; wait_q();
   endtask

   task automatic send_stop();
      sda_m = 1'b0; wait_q();
      scl   = 1'b1; wait_q();
      sda_m = 1'b1; wait_q();
   endtask

   task automatic clock_bit(input logic b, output logic got);
      sda_m = b;    wait_q();
      scl   = 1'b1; wait_q();
      got   = sda_bus; wait_q();
      scl   = 1'b0; wait_q();
   endtask

   task automatic write_byte(input logic [7:0] b, output logic acked);
      logic x;
      for (int i = 7; i >= 0; i--) clock_bit(b[i], x);
      clock_bit(1'b1, x);
      acked = ~x;
   endtask

   task automatic read_byte(input logic ack, output logic [7:0] b);
      logic x;
      for (int i = 7; i >= 0; i--) begin
         clock_bit(1'b1, x);
         b[i] = x;
      end
      clock_bit(~ack, x);
   endtask

   function automatic logic [31:0] out_vec();
      return 32'({sda_oe, rx_data, rx_valid, tx_req, rw, busy, start_p, stop_p});
   endfunction

   // Reference: target ACKs only its address; writes are received and ACKed per ack_en,
   // master stops after the first NACK; reads return the queued tx bytes in order.
   task automatic run_txn(input logic [6:0] addr, input logic rdn, input int n, input logic en);
      int         s0, p0, r0, t0, o0, nrx;
      logic       acked, match, nacked;
      logic [7:0] b;
      s0 = start_cnt; p0 = stop_cnt; r0 = rx_cnt; t0 = tx_cnt; o0 = oe_cnt;
      nrx = 0; nacked = 1'b0;
      match = (addr == TADDR);
      ack_en = en;
      if (rdn) for (int i = 0; i < n; i++) tx_mem[(t0 + 1 + i) % 16] = wdata[i];
      send_start();
      write_byte({addr, rdn}, acked);
      check_eq("addr_ack", 32'(acked), 32'(match));
      if (!match) begin
         check_eq("busy_miss", 32'(busy), 0);
         write_byte(8'hFF, acked);
         check_eq("ignored_ack", 32'(acked), 0);
      end else begin
         check_eq("busy_match", 32'(busy), 1);
         check_eq("rw", 32'(rw), 32'(rdn));
         if (!rdn) begin
            for (int i = 0; i < n; i++) begin
               write_byte(wdata[i], acked);
               nrx++;
               check_eq("data_ack", 32'(acked), 32'(en));
               check_eq("rx_data", 32'(rx_data), 32'(wdata[i]));
               check_eq("rx_log", 32'(rx_log[(r0 + i) % 16]), 32'(wdata[i]));
               if (!acked) begin
                  nacked = 1'b1;
                  break;
               end
            end
         end else begin
            for (int i = 0; i < n; i++) begin
               read_byte(i != n - 1, b);
               check_eq("tx_byte", 32'(b), 32'(wdata[i]));
            end
            nacked = 1'b1;
            check_eq("tx_released", 32'(sda_oe), 0);
         end
         check_eq("busy_pre_stop", 32'(busy), 32'(!nacked));
      end
      send_stop();
      wait_q();
      check_eq("start_cnt", start_cnt - s0, 1);
      check_eq("stop_cnt", stop_cnt - p0, 1);
      check_eq("rx_cnt", rx_cnt - r0, nrx);
      check_eq("tx_cnt", tx_cnt - t0, (match && rdn) ? n : 0);
      check_eq("busy_idle", 32'(busy), 0);
      if (!match) check_eq("oe_never", oe_cnt - o0, 0);
   endtask

   initial begin
      logic       acked;
      logic [7:0] b;
      int         s0, p0;
      logic [6:0] a;
      for (int i = 0; i < 16; i++) tx_mem[i] = 8'h00;
      for (int i = 0; i < 16; i++) rx_log[i] = 8'h00;
      rst = 1'b1; scl = 1'b1; sda_m = 1'b1; ack_en = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check_eq("reset_outs", out_vec(), 0);
      rst = 1'b0;
      wait_q();
      check_eq("post_reset_outs", out_vec(), 0);

      // Directed write, mismatch, read, write NACK.
      wdata[0] = 8'hA5; wdata[1] = 8'h3C;
      run_txn(7'h50, 1'b0, 2, 1'b1);
      run_txn(7'h51, 1'b0, 1, 1'b1);
      wdata[0] = 8'hC3; wdata[1] = 8'h7E;
      run_txn(7'h50, 1'b1, 2, 1'b1);
      wdata[0] = 8'h11;
      run_txn(7'h50, 1'b0, 1, 1'b0);

      // Repeated START: write then read without STOP in between.
      s0 = start_cnt; p0 = stop_cnt; ack_en = 1'b1;
      send_start();
      write_byte(8'hA0, acked);
      check_eq("sr_addr_w", 32'(acked), 1);
      check_eq("sr_rw0", 32'(rw), 0);
      write_byte(8'h01, acked);
      check_eq("sr_data_ack", 32'(acked), 1);
      tx_mem[(tx_cnt + 1) % 16] = 8'h96;
      send_start();
      write_byte(8'hA1, acked);
      check_eq("sr_addr_r", 32'(acked), 1);
      check_eq("sr_rw1", 32'(rw), 1);
      read_byte(1'b0, b);
      check_eq("sr_byte", 32'(b), 32'h96);
      send_stop();
      wait_q();
      check_eq("sr_starts", start_cnt - s0, 2);
      check_eq("sr_stops", stop_cnt - p0, 1);

      // Async reset while the target pulls SDA low for a 0 data bit.
      tx_mem[(tx_cnt + 1) % 16] = 8'h3C;
      send_start();
      write_byte(8'hA1, acked);
      check_eq("rst_addr_ack", 32'(acked), 1);
      check_eq("rst_tx_drive", 32'(sda_oe), 1);
      rst = 1'b1;
      #1;
      check_eq("rst_async_outs", out_vec(), 0);
      scl = 1'b1; wait_q();
      sda_m = 1'b1; wait_q();
      rst = 1'b0;
      wait_q();
      check_eq("rst_release_outs", out_vec(), 0);
      wdata[0] = 8'h5A; wdata[1] = 8'hE7;
      run_txn(7'h50, 1'b0, 2, 1'b1);

      // Randomized transactions.
      for (int t = 0; t < 10; t++) begin
         if ($urandom_range(0, 3) != 0) a = TADDR;
         else begin
            a = 7'($urandom_range(0, 127));
            if (a == TADDR) a = a ^ 7'h01;
         end
         for (int i = 0; i < 8; i++) wdata[i] = 8'($urandom_range(0, 255));
         run_txn(a, 1'($urandom_range(0, 1)), int'($urandom_range(1, 3)),
                 1'($urandom_range(0, 3) != 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
